vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- UPSCALE_FACTOR, 5, screen pixels per sprite pixel
- TILE_SIZE, 8, sprite pixels per tile
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in, in, 1, pixel-domain clock
- reset, in, 1, reset; asynchronous, active-low
- pix_en, in, 1, pixel advance enable; tie high when clk_in is the pixel clock
- counter_H, out, 10, horizontal pixel index 0..799
- counter_V, out, 10, vertical line index 0..524
- hsync, out, 1, active-low horizontal sync
- vsync, out, 1, active-low vertical sync
- display_on, out, 1, high inside the 640x480 active region
- tile_H, out, 4, horizontal tile index 0..15
- tile_V, out, 4, vertical tile index 0..11
- px_H, out, 3, sprite column within tile 0..7
- px_V, out, 3, sprite row within tile 0..7
- sub_H, out, 3, upscale phase within sprite column 0..4
- sub_V, out, 3, upscale phase within sprite row 0..4
- tile_next, out, 1, one-cycle strobe: the next pixel starts a new tile
- line_tick, out, 1, one-cycle strobe on the last pixel of each line
- frame_tick, out, 1, one-cycle strobe on the last pixel of each frame

Function
REQ-003 All outputs SHALL be registered; all state SHALL change only on rising clk_in edges where pix_en=1; with pix_en=0, every output SHALL hold.
REQ-004 counter_H SHALL increment by 1 per enabled cycle and wrap from H_total-1 (799) to 0.
REQ-005 counter_V SHALL increment only on an H wrap, and SHALL wrap from V_total-1 (524) to 0 on an H wrap.
REQ-006 hsync SHALL be 0 for counter_H in [656,751], otherwise 1; vsync SHALL be 0 for counter_V in [490,491], otherwise 1.
REQ-007 display_on SHALL be 1 iff counter_H<640 and counter_V<480.
REQ-008 hsync, vsync and display_on SHALL be computed from next-state counters so they align with the counter values presented in the same cycle (zero skew).
REQ-009 sub_H SHALL count 0..4 across the active region; on the 4->0 wrap px_H SHALL increment; on the px_H 7->0 wrap tile_H SHALL increment. When counter_H>=640, sub_H, px_H and tile_H SHALL be held at 0.
REQ-010 sub_V, px_V and tile_V SHALL advance with the same cascade, stepping once per H wrap while the next counter_V<480. They SHALL be held at 0 during vertical blanking and cleared on the frame wrap.
REQ-011 tile_next SHALL be 1 in the cycles where (display_on and sub_H=4 and px_H=7) or counter_H=799; it SHALL never be asserted on two consecutive enabled cycles.
REQ-012 line_tick SHALL be 1 iff counter_H=799. frame_tick SHALL be 1 iff counter_H=799 and counter_V=524.
REQ-013 Width rules: all compares SHALL be unsigned. Cascade counters SHALL never exceed their ranges, including tile_H=15 at counter_H=639 and tile_V=11 at counter_V=479.
REQ-014 A pix_en deassertion at any boundary (tile, line or frame wrap) SHALL freeze state without loss; the wrap SHALL complete on the next enabled cycle.

Reset
REQ-015 While reset=0, all counters SHALL be 0; hsync=1, vsync=1, display_on=1; tile_next, line_tick and frame_tick SHALL be 0.
REQ-016 Reset assertion SHALL take effect immediately, asynchronously, including mid-line or mid-frame; after release, the first enabled cycle SHALL advance counter_H to 1.

Structure
REQ-017 The timing constants (H/V totals, sync start/end, UPSCALE_FACTOR, TILE_SIZE, tile counts 16x12) SHALL live in a shared display package used with the frame buffer controller.
REQ-018 One sub-module, tile_cascade (sub/px/tile counter with clear, step and wrap-out), SHALL be instantiated twice, once for H and once for V.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Free run, pix_en=1, for 2 frames -> exactly 420000 cycles per frame; frame_tick once per frame; hsync low for 96 cycles per line; vsync low for 1600 cycles per frame.
- Active scan -> at counter_H=39: sub_H=4, px_H=7, tile_H=0, tile_next=1; at counter_H=40: tile_H=1; at counter_H=639: tile_H=15; at counter_H=640: tile_H=0.
- Line 479 -> tile_V=11, px_V=7, sub_V=4; at line 480: all V cascade outputs 0 and display_on=0.
- pix_en toggled 1/0 at random, including at counter_H=799 with counter_V=524 -> output sequence identical to the free run with disabled cycles removed.
- reset pulsed low at counter_H=300, counter_V=200 -> all outputs at REQ-015 values within the same cycle; restart from (0,0).
- Cross-check against a reference model each cycle -> display_on equals (counter_H<640 and counter_V<480) with zero skew.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared display timing constants for the VGA timing generator and frame buffer controller.
// Holds the 640x480@60 geometry, sprite/tile scaling and the helpers that derive totals and sync windows.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_C       = 640;
  localparam int H_FP_C           = 16;
  localparam int H_SYNC_C         = 96;
  localparam int H_BP_C           = 48;
  localparam int V_ACTIVE_C       = 480;
  localparam int V_FP_C           = 10;
  localparam int V_SYNC_C         = 2;
  localparam int V_BP_C           = 33;
  localparam int UPSCALE_FACTOR_C = 5;
  localparam int TILE_SIZE_C      = 8;
  localparam int TILES_H_C        = 16;
  localparam int TILES_V_C        = 12;

  localparam int CNT_W  = 10;
  localparam int TILE_W = $clog2(TILES_H_C);
  localparam int PX_W   = 3;
  localparam int SUB_W  = 3;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_tile_cascade.sv
// Sub-pixel / sprite-pixel / tile counter chain; clear wins over step, state loads only when enabled.
// wrap_o flags that the next-state position is the last upscale phase of the last sprite pixel in a tile.
module tile_cascade
  import vga_timing_gen_pkg::*;
#(
  parameter int SUB_N  = UPSCALE_FACTOR_C,
  parameter int PX_N   = TILE_SIZE_C,
  parameter int TILE_N = TILES_H_C
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              step_i,
  output logic [SUB_W-1:0]  sub_o,
  output logic [PX_W-1:0]   px_o,
  output logic [TILE_W-1:0] tile_o,
  output logic              wrap_o
);

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_N - 1);
  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(PX_N - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILE_N - 1);

  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [TILE_W-1:0] tile_q, tile_d;

  always_comb begin
    sub_d  = sub_q;
    px_d   = px_q;
    tile_d = tile_q;
    if (clr_i) begin
      sub_d  = '0;
      px_d   = '0;
      tile_d = '0;
    end else if (step_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        if (px_q == PX_LAST) begin
          px_d   = '0;
          // Tile index wraps rather than overflowing its field if the clear ever arrives late.
          tile_d = (tile_q == TILE_LAST) ? '0 : tile_q + TILE_W'(1);
        end else begin
          px_d = px_q + PX_W'(1);
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  assign wrap_o = (sub_d == SUB_LAST) && (px_d == PX_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q  <= '0;
      px_q   <= '0;
      tile_q <= '0;
    end else if (en_i) begin
      sub_q  <= sub_d;
      px_q   <= px_d;
      tile_q <= tile_d;
    end
  end

  assign sub_o  = sub_q;
  assign px_o   = px_q;
  assign tile_o = tile_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with sprite/tile coordinates; every output is a register loaded from next-state
// counters so sync, blanking and tile coordinates line up with counter_H/counter_V in the same cycle.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_C,
  parameter int H_FP           = H_FP_C,
  parameter int H_SYNC         = H_SYNC_C,
  parameter int H_BP           = H_BP_C,
  parameter int V_ACTIVE       = V_ACTIVE_C,
  parameter int V_FP           = V_FP_C,
  parameter int V_SYNC         = V_SYNC_C,
  parameter int V_BP           = V_BP_C,
  parameter int UPSCALE_FACTOR = UPSCALE_FACTOR_C,
  parameter int TILE_SIZE      = TILE_SIZE_C
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              pix_en,
  output logic [CNT_W-1:0]  counter_H,
  output logic [CNT_W-1:0]  counter_V,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [TILE_W-1:0] tile_H,
  output logic [TILE_W-1:0] tile_V,
  output logic [PX_W-1:0]   px_H,
  output logic [PX_W-1:0]   px_V,
  output logic [SUB_W-1:0]  sub_H,
  output logic [SUB_W-1:0]  sub_V,
  output logic              tile_next,
  output logic              line_tick,
  output logic              frame_tick
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_start(H_ACTIVE, H_FP) + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_start(V_ACTIVE, V_FP) + V_SYNC - 1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d, disp_q, disp_d;
  logic             tnext_q, tnext_d, line_q, line_d, frame_q, frame_d;
  logic             h_wrap, h_clr, v_clr, h_tile_wrap, v_wrap_unused;

  assign h_wrap = (h_q == H_LAST);
  assign h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
  assign v_d    = h_wrap ? ((v_q == V_LAST) ? '0 : v_q + CNT_W'(1)) : v_q;

  // Cascades sit at zero outside the active region; a next index of 0 also restarts them.
  assign h_clr  = (h_d >= H_ACT) || (h_d == '0);
  assign v_clr  = (v_d >= V_ACT) || (v_d == '0);

  assign disp_d  = (h_d < H_ACT) && (v_d < V_ACT);
  assign hs_d    = !in_range(h_d, HS_START, HS_END);
  assign vs_d    = !in_range(v_d, VS_START, VS_END);
  assign tnext_d = (disp_d && h_tile_wrap) || (h_d == H_LAST);
  assign line_d  = (h_d == H_LAST);
  assign frame_d = (h_d == H_LAST) && (v_d == V_LAST);

  tile_cascade #(
    .SUB_N  (UPSCALE_FACTOR),
    .PX_N   (TILE_SIZE),
    .TILE_N (TILES_H_C)
  ) u_cascade_h (
    .clk_i  (clk_in),
    .rst_ni (reset),
    .en_i   (pix_en),
    .clr_i  (h_clr),
    .step_i (1'b1),
    .sub_o  (sub_H),
    .px_o   (px_H),
    .tile_o (tile_H),
    .wrap_o (h_tile_wrap)
  );

  tile_cascade #(
    .SUB_N  (UPSCALE_FACTOR),
    .PX_N   (TILE_SIZE),
    .TILE_N (TILES_V_C)
  ) u_cascade_v (
    .clk_i  (clk_in),
    .rst_ni (reset),
    .en_i   (pix_en),
    .clr_i  (v_clr),
    .step_i (h_wrap),
    .sub_o  (sub_V),
    .px_o   (px_V),
    .tile_o (tile_V),
    .wrap_o (v_wrap_unused)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      disp_q  <= 1'b1;
      tnext_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (pix_en) begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      disp_q  <= disp_d;
      tnext_q <= tnext_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign counter_H  = h_q;
  assign counter_V  = v_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign display_on = disp_q;
  assign tile_next  = tnext_q;
  assign line_tick  = line_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a pixel-position model predicts every output each cycle,
// plus hand-computed spot values at tile, line and frame boundaries and an asynchronous reset pulse.
module tb_vga_timing_gen;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] counter_H, counter_V;
  logic       hsync, vsync, display_on;
  logic [3:0] tile_H, tile_V;
  logic [2:0] px_H, px_V, sub_H, sub_V;
  logic       tile_next, line_tick, frame_tick;

  vga_timing_gen dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .pix_en     (pix_en),
    .counter_H  (counter_H),
    .counter_V  (counter_V),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .tile_H     (tile_H),
    .tile_V     (tile_V),
    .px_H       (px_H),
    .px_V       (px_V),
    .sub_H      (sub_H),
    .sub_V      (sub_V),
    .tile_next  (tile_next),
    .line_tick  (line_tick),
    .frame_tick (frame_tick)
  );

  always #5 clk_in = ~clk_in;

  localparam int BUDGET = 1_100_000;

  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   mh = 0, mv = 0;
  int   fcnt = 0, hs_low = 0, vs_low = 0, frames_seen = 0, wrap_hold = 0;
  int   cycles = 0;
  logic en_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (model h=%0d v=%0d)", tag, obs, exp, mh, mv);
    end
  endtask

  function automatic logic [63:0] exp_vec(input int h, input int v);
    logic disp, tn;
    int   sh, ph, th, sv, pv, tv;
    disp = (h < 640) && (v < 480);
    sh = (h < 640) ? h % 5 : 0;
    ph = (h < 640) ? (h / 5) % 8 : 0;
    th = (h < 640) ? h / 40 : 0;
    sv = (v < 480) ? v % 5 : 0;
    pv = (v < 480) ? (v / 5) % 8 : 0;
    tv = (v < 480) ? v / 40 : 0;
    tn = (disp && sh == 4 && ph == 7) || (h == 799);
    return {18'd0, 10'(h), 10'(v), !(h >= 656 && h <= 751), !(v == 490 || v == 491), disp,
            4'(th), 4'(tv), 3'(ph), 3'(pv), 3'(sh), 3'(sv), tn, (h == 799), (h == 799 && v == 524)};
  endfunction

  function automatic logic [63:0] obs_vec();
    return {18'd0, counter_H, counter_V, hsync, vsync, display_on, tile_H, tile_V,
            px_H, px_V, sub_H, sub_V, tile_next, line_tick, frame_tick};
  endfunction

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk_in);
    cycles++;
    if (en) begin
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(negedge clk_in);
    chk("outputs", obs_vec(), exp_vec(mh, mv));
    chk("disp_xchk", 64'(display_on), 64'((counter_H < 10'd640) && (counter_V < 10'd480)));
  endtask

  initial begin
    reset  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_vec", obs_vec(), exp_vec(0, 0));
    chk("reset_hsync", 64'(hsync), 64'(1));
    chk("reset_disp", 64'(display_on), 64'(1));
    chk("reset_tnext", 64'(tile_next), 64'(0));
    reset = 1'b1;
    fcnt  = 1;

    while (!(frames_seen == 2 && mh == 300 && mv == 200) && cycles < BUDGET && n_fail < 50) begin
      en_r = 1'b1;
      if (frames_seen >= 1 && (mv >= 523 || mv < 2)) en_r = ($urandom_range(0, 3) != 0);
      if (frames_seen == 2 && mh == 799 && mv == 524 && wrap_hold < 3) begin
        en_r = 1'b0;
        wrap_hold++;
      end
      step(en_r);
      if (cycles == 1) chk("first_H", 64'(counter_H), 64'(1));
      if (en_r) begin
        fcnt++;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (frames_seen == 0) begin
          if (mv == 0 && mh == 39) begin
            chk("h39_sub", 64'(sub_H), 64'(4));
            chk("h39_px", 64'(px_H), 64'(7));
            chk("h39_tile", 64'(tile_H), 64'(0));
            chk("h39_tnext", 64'(tile_next), 64'(1));
          end
          if (mv == 0 && mh == 40)  chk("h40_tile", 64'(tile_H), 64'(1));
          if (mv == 0 && mh == 639) chk("h639_tile", 64'(tile_H), 64'(15));
          if (mv == 0 && mh == 640) begin
            chk("h640_tile", 64'(tile_H), 64'(0));
            chk("h640_disp", 64'(display_on), 64'(0));
          end
          if (mv == 479 && mh == 0) begin
            chk("v479_tile", 64'(tile_V), 64'(11));
            chk("v479_px", 64'(px_V), 64'(7));
            chk("v479_sub", 64'(sub_V), 64'(4));
          end
          if (mv == 480 && mh == 0) begin
            chk("v480_cascade", 64'({tile_V, px_V, sub_V}), 64'(0));
            chk("v480_disp", 64'(display_on), 64'(0));
          end
        end
        if (line_tick) begin
          chk("hsync_low_per_line", 64'(hs_low), 64'(96));
          hs_low = 0;
        end
        if (frame_tick) begin
          chk("frame_len", 64'(fcnt), 64'(420000));
          chk("vsync_low_per_frame", 64'(vs_low), 64'(1600));
          fcnt   = 0;
          vs_low = 0;
          frames_seen++;
        end
      end
    end

    chk("reach_H", 64'(counter_H), 64'(300));
    chk("reach_V", 64'(counter_V), 64'(200));
    chk("frames_seen", 64'(frames_seen), 64'(2));
    chk("wrap_stall", 64'(wrap_hold), 64'(3));

    // Reset lands between clock edges: outputs must clear without waiting for an edge.
    #2;
    reset = 1'b0;
    #1;
    mh = 0;
    mv = 0;
    chk("async_reset_vec", obs_vec(), exp_vec(0, 0));
    @(negedge clk_in);
    chk("reset_hold_vec", obs_vec(), exp_vec(0, 0));
    reset = 1'b1;
    step(1'b1);
    chk("restart_H", 64'(counter_H), 64'(1));
    chk("restart_V", 64'(counter_V), 64'(0));
    for (int i = 0; i < 900 && n_fail < 50; i++) step(1'b1);
    chk("restart_end_H", 64'(counter_H), 64'(101));
    chk("restart_end_V", 64'(counter_V), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
